// File: rtl/layer_stage_ctrl_if.sv
// layer_stage_ctrl_if: control bundle between the layer sequencer and its stage engines
interface layer_stage_ctrl_if #(
    parameter int LW = 4
);
    logic          ln_start;
    logic [6:0]    stage_done;
    logic          err_clr;
    logic [6:0]    stage_start;
    logic          linear2_done;
    logic [LW-1:0] layer_idx;
    logic [1:0]    lin_sel;
    logic          lin_busy;
    logic          busy;
    logic [1:0]    err;

    modport master (
        output ln_start, stage_done, err_clr,
        input  stage_start, linear2_done, layer_idx, lin_sel, lin_busy, busy, err
    );

    modport slave (
        input  ln_start, stage_done, err_clr,
        output stage_start, linear2_done, layer_idx, lin_sel, lin_busy, busy, err
    );
endinterface

// File: rtl/layer_stage_ctrl.sv
// layer_stage_ctrl: sequences LN1..FC2 of one transformer layer with watchdog and sticky errors
module layer_stage_ctrl #(
    parameter int NUM_LAYER   = 12,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic               clk,
    input logic               reset_n,
    layer_stage_ctrl_if.slave bus_io
);
    localparam int LW = NUM_LAYER > 1 ? $clog2(NUM_LAYER) : 1;
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, LN1, QKV, ATTN, PROJ, LN2, FC1, FC2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    stage_start_q, stage_start_d;
    logic          linear2_done_q, linear2_done_d;
    logic [LW-1:0] layer_idx_q, layer_idx_d;
    logic [1:0]    lin_sel_q, lin_sel_d;
    logic          lin_busy_q, lin_busy_d;
    logic          busy_q, busy_d;
    logic [1:0]    err_q, err_d;
    logic [6:0]    own_mask;
    logic          hit, stray, timeout, perr, fc2_done;

    // next state and next registered outputs; bit k of stage_done belongs to state k+1
    always_comb begin
        own_mask       = 7'((8'd1 << state_q) >> 1);
        hit            = |(bus_io.stage_done & own_mask);
        stray          = |(bus_io.stage_done & ~own_mask);
        timeout        = (TIMEOUT_CYC != 0) && (state_q != IDLE) && !hit && (cnt_q == CW'(TIMEOUT_CYC));
        perr           = stray || (bus_io.ln_start && state_q != IDLE);
        fc2_done       = hit && state_q == FC2;
        state_d        = state_q == IDLE ? (bus_io.ln_start ? LN1 : IDLE)
                       : hit ? (fc2_done ? IDLE : state_t'(state_q + 3'd1))
                       : timeout ? IDLE : state_q;
        stage_start_d  = state_d != state_q ? 7'((8'd1 << state_d) >> 1) : 7'd0;
        linear2_done_d = fc2_done;
        layer_idx_d    = !fc2_done ? layer_idx_q
                       : layer_idx_q == LW'(NUM_LAYER - 1) ? '0 : layer_idx_q + LW'(1);
        lin_sel_d      = state_d == QKV ? 2'd0 : state_d == PROJ ? 2'd1
                       : state_d == FC1 ? 2'd2 : state_d == FC2 ? 2'd3 : lin_sel_q;
        lin_busy_d     = state_d inside {QKV, PROJ, FC1, FC2};
        busy_d         = state_d != IDLE;
        cnt_d          = (state_d == state_q && state_d != IDLE) ? cnt_q + CW'(1) : '0;
        err_d          = (bus_io.err_clr ? 2'b00 : err_q) | {timeout, perr};
    end

    // state, stage counter and all outputs registered together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stage_start_q  <= '0;
            linear2_done_q <= 1'b0;
            layer_idx_q    <= '0;
            lin_sel_q      <= 2'd0;
            lin_busy_q     <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 2'b00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stage_start_q  <= stage_start_d;
            linear2_done_q <= linear2_done_d;
            layer_idx_q    <= layer_idx_d;
            lin_sel_q      <= lin_sel_d;
            lin_busy_q     <= lin_busy_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
        end
    end

    assign bus_io.stage_start  = stage_start_q;
    assign bus_io.linear2_done = linear2_done_q;
    assign bus_io.layer_idx    = layer_idx_q;
    assign bus_io.lin_sel      = lin_sel_q;
    assign bus_io.lin_busy     = lin_busy_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.err          = err_q;
endmodule

// File: tb/tb_layer_stage_ctrl.sv
// tb_layer_stage_ctrl: directed and random checks of the layer sequencer against a stage-level model
module tb_layer_stage_ctrl;
    localparam int NL = 12;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    layer_stage_ctrl_if #(.LW(4)) bus_io ();

    layer_stage_ctrl #(.NUM_LAYER(NL), .TIMEOUT_CYC(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_io  (bus_io)
    );

    int total = 0;
    int bad = 0;
    int dut_l2 = 0;
    int m_stage, m_layer, m_cnt, m_sel;
    logic [6:0] m_start;
    logic       m_l2;
    logic [1:0] m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/start"}, 32'(bus_io.stage_start), 32'(m_start));
        chk({tag, "/l2"}, 32'(bus_io.linear2_done), 32'(m_l2));
        chk({tag, "/idx"}, 32'(bus_io.layer_idx), 32'(m_layer));
        chk({tag, "/sel"}, 32'(bus_io.lin_sel), 32'(m_sel));
        chk({tag, "/lbusy"}, 32'(bus_io.lin_busy), 32'(m_stage inside {2, 4, 6, 7}));
        chk({tag, "/busy"}, 32'(bus_io.busy), 32'(m_stage != 0));
        chk({tag, "/err"}, 32'(bus_io.err), 32'(m_err));
    endtask

    task automatic model_reset();
        m_stage = 0;
        m_layer = 0;
        m_cnt   = 0;
        m_sel   = 0;
        m_start = '0;
        m_l2    = 1'b0;
        m_err   = 2'b00;
    endtask

    // stage numbers: 0 idle, 1..7 = LN1..FC2; stage s owns stage_done bit s-1
    task automatic model_step(input logic ls, input logic [6:0] sd, input logic ec);
        int cur;
        logic [6:0] own;
        logic hit, stray, to, perr;
        cur   = m_stage;
        own   = cur != 0 ? 7'(1 << (cur - 1)) : 7'd0;
        hit   = (sd & own) != 0;
        stray = (sd & ~own) != 0;
        to    = cur != 0 && !hit && m_cnt == TO;
        perr  = stray || (ls && cur != 0);
        m_start = '0;
        m_l2    = 1'b0;
        if (cur == 0) begin
            if (ls) begin
                m_stage = 1;
                m_cnt   = 0;
                m_start = 7'd1;
            end
        end else if (hit && cur == 7) begin
            m_stage = 0;
            m_l2    = 1'b1;
            m_layer = (m_layer + 1) % NL;
        end else if (hit) begin
            m_stage = cur + 1;
            m_start = 7'(1 << cur);
            m_cnt   = 0;
        end else if (to) begin
            m_stage = 0;
        end else begin
            m_cnt++;
        end
        m_err = (ec ? 2'b00 : m_err) | {to, perr};
        case (m_stage)
            2: m_sel = 0;
            4: m_sel = 1;
            6: m_sel = 2;
            7: m_sel = 3;
            default: ;
        endcase
    endtask

    task automatic step(input logic ls, input logic [6:0] sd, input logic ec, input string tag);
        bus_io.ln_start   = ls;
        bus_io.stage_done = sd;
        bus_io.err_clr    = ec;
        @(posedge clk);
        if (reset_n) model_step(ls, sd, ec);
        else model_reset();
        #1;
        bus_io.ln_start   = 1'b0;
        bus_io.stage_done = '0;
        bus_io.err_clr    = 1'b0;
        if (bus_io.linear2_done === 1'b1) dut_l2++;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) step(1'b0, 7'd0, 1'b0, tag);
    endtask

    task automatic run_stages(input int first, input int last, input int gap, input string tag);
        for (int k = first; k <= last; k++) begin
            idle(gap, tag);
            step(1'b0, 7'(1 << k), 1'b0, tag);
        end
    endtask

    task automatic run_layer(input int gap, input string tag);
        step(1'b1, 7'd0, 1'b0, tag);
        run_stages(0, 6, gap, tag);
    endtask

    initial begin
        bus_io.ln_start   = 1'b0;
        bus_io.stage_done = '0;
        bus_io.err_clr    = 1'b0;
        model_reset();
        idle(2, "reset");
        reset_n = 1'b1;
        idle(2, "post_reset");

        run_layer(3, "nominal");
        chk("nominal_idx", 32'(bus_io.layer_idx), 32'd1);

        run_layer(0, "same_cycle");

        dut_l2 = 0;
        for (int i = 0; i < NL; i++) run_layer($urandom_range(0, 4), "back2back");
        chk("b2b_count", 32'(dut_l2), 32'(NL));
        chk("b2b_idx", 32'(bus_io.layer_idx), 32'd2);

        step(1'b1, 7'd0, 1'b0, "stray");
        run_stages(0, 0, 1, "stray");
        step(1'b0, 7'b0000100, 1'b0, "stray");
        chk("stray_err", 32'(bus_io.err), 32'd1);
        idle(1, "stray");
        step(1'b0, 7'd0, 1'b1, "stray_clr");
        chk("stray_clr_err", 32'(bus_io.err), 32'd0);
        run_stages(1, 6, 1, "stray");

        step(1'b1, 7'd0, 1'b0, "restart");
        run_stages(0, 2, 2, "restart");
        step(1'b1, 7'd0, 1'b0, "restart_ign");
        chk("restart_err", 32'(bus_io.err), 32'd1);
        run_stages(3, 6, 2, "restart");
        step(1'b0, 7'd0, 1'b1, "restart_clr");

        dut_l2 = 0;
        step(1'b1, 7'd0, 1'b0, "timeout");
        run_stages(0, 1, 1, "timeout");
        idle(8, "timeout_wait");
        chk("to_busy_e8", 32'(bus_io.busy), 32'd1);
        idle(1, "timeout_hit");
        chk("to_busy_e9", 32'(bus_io.busy), 32'd0);
        chk("to_err", 32'(bus_io.err), 32'd2);
        chk("to_no_l2", 32'(dut_l2), 32'd0);
        idle(2, "timeout_after");
        step(1'b0, 7'd0, 1'b1, "timeout_clr");

        for (int i = 0; i < 400; i++) begin
            logic       ls;
            logic [6:0] sd;
            int         r;
            ls = $urandom_range(0, 9) == 0;
            r  = $urandom_range(0, 99);
            sd = (m_stage != 0 && r < 40) ? 7'(1 << (m_stage - 1))
               : (r < 45) ? 7'($urandom_range(0, 127)) : 7'd0;
            step(ls, sd, $urandom_range(0, 19) == 0, "random");
        end

        reset_n = 1'b0;
        idle(1, "rst_prep");
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) run_layer(1, "to_five");
        step(1'b1, 7'd0, 1'b0, "to_fc1");
        run_stages(0, 4, 1, "to_fc1");
        chk("fc1_idx", 32'(bus_io.layer_idx), 32'd5);
        chk("fc1_sel", 32'(bus_io.lin_sel), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async_idx", 32'(bus_io.layer_idx), 32'd0);
        idle(2, "rst_hold");
        reset_n = 1'b1;
        idle(3, "rst_released");
        run_layer(2, "after_rst");
        chk("after_rst_idx", 32'(bus_io.layer_idx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
